// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults for the UART receive/transmit buffering.
// Any receiver or transmitter instance should take its widths from here.
package uart_rx_fifo_pkg;

  localparam int UART_DBITS      = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;

endpackage

// File: rtl/uart_rx_fifo_sync_edge_det.sv
// Two-flop synchroniser followed by a rising-edge detector, in the PCLK domain.
// Shared by the receive and transmit paths.
module sync_edge_det (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic async_in,
  output logic rise
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [2:0] live_q, live_d;

  // live_q fills with ones after reset; prev_q is trusted only once it holds a real
  // sample, so an input already high at reset release never produces a rise.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    live_d  = {live_q[1:0], 1'b1};
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      live_q  <= 3'b000;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      live_q  <= live_d;
    end
  end

  assign rise = sync2_q && !prev_q && live_q[2];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures each completed frame into a
// synchronous FIFO and serves bytes through a registered rd_en/rd_valid port.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DBITS  = UART_DBITS,
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              rx_done,
  input  logic [DBITS-1:0]  rx_dout,
  input  logic              rd_en,
  output logic [DBITS-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam int PW = ADDR_W + 1;

  logic             push;
  logic             pop;
  logic             wr_en;
  logic             ovr_set;
  logic             empty_w;
  logic             full_w;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DBITS-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             overrun_q, overrun_d;

  logic [DBITS-1:0] mem_q [DEPTH];

  sync_edge_det u_sync_edge_det (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .async_in (rx_done),
    .rise     (push)
  );

  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign pop     = rd_en && !empty_w;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign wr_en   = push && (!full_w || pop);
  assign ovr_set = push && full_w && !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overrun_d  = overrun_q;

    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PW'(1);
      rd_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      rd_valid_d = 1'b1;
    end

    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage is deliberately left unreset; the pointers alone define what is valid.
  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= rx_dout;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = wr_ptr_q - rd_ptr_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: a per-cycle vector table, directed corner sequences,
// and a randomized run checked against a queue-based model of the buffer.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       PCLK;
  logic       PRESETn;
  logic       rx_done;
  logic [7:0] rx_dout;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overrun;
  logic       ovr_clr;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo dut (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .rx_done  (rx_done),
    .rx_dout  (rx_dout),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic       done;
    logic [7:0] dout;
    logic       rd;
    logic       clr;
    logic [4:0] cnt;
    logic       emp;
    logic       vld;
    logic [7:0] rdd;
  } vec_t;

  vec_t tbl [9];

  // reference model state for the random phase
  logic [7:0] mq [$];
  int         pend_edge [$];
  logic [7:0] pend_data [$];
  logic       m_ovr;
  logic       m_vld;
  logic [7:0] m_rd;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", nm, act, exp);
    end
  endtask

  // Holds rx_done high for hi cycles and returns once the write edge has passed.
  task automatic send_frame(input logic [7:0] d, input int hi);
    rx_dout = d;
    rx_done = 1'b1;
    repeat (hi) step();
    rx_done = 1'b0;
    repeat ((hi < 3 ? 3 - hi : 0) + 1) step();
  endtask

  task automatic read_one(input logic [7:0] exp, input string nm);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk1({nm, " rd_valid"}, rd_valid, 1'b1);
    chk8({nm, " rd_data"}, rd_data, exp);
  endtask

  initial begin
    logic [7:0] wq [$];
    logic [7:0] d;
    int         cyc;
    int         since;
    int         hi_left;
    int         thr;
    logic       pop_m;
    logic       push_m;

    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 8'hA5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'hA5};
    tbl[4] = '{1'b0, 8'hA5, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
    tbl[5] = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
    tbl[6] = '{1'b0, 8'h3C, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'hA5};
    tbl[7] = '{1'b0, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5};
    tbl[8] = '{1'b0, 8'h3C, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 8'h3C};

    // T1: reset with rx_done held high
    PRESETn = 1'b0;
    rx_done = 1'b1;
    rx_dout = 8'h5A;
    rd_en   = 1'b0;
    ovr_clr = 1'b0;
    repeat (5) step();
    PRESETn = 1'b1;
    chk1("reset empty", empty, 1'b1);
    chk1("reset full", full, 1'b0);
    chk5("reset count", count, 5'd0);
    chk1("reset overrun", overrun, 1'b0);
    chk1("reset rd_valid", rd_valid, 1'b0);
    chk8("reset rd_data", rd_data, 8'h00);
    repeat (6) step();
    chk5("no push from high-at-release", count, 5'd0);
    rx_done = 1'b0;
    repeat (3) step();
    chk5("no push after release drop", count, 5'd0);

    // T2: per-cycle vectors around a single byte and a one-cycle rx_done pulse
    for (int i = 0; i < 9; i++) begin
      rx_done = tbl[i].done;
      rx_dout = tbl[i].dout;
      rd_en   = tbl[i].rd;
      ovr_clr = tbl[i].clr;
      step();
      chk5($sformatf("vec%0d count", i), count, tbl[i].cnt);
      chk1($sformatf("vec%0d empty", i), empty, tbl[i].emp);
      chk1($sformatf("vec%0d rd_valid", i), rd_valid, tbl[i].vld);
      chk8($sformatf("vec%0d rd_data", i), rd_data, tbl[i].rdd);
    end
    rd_en = 1'b0;
    step();

    // T3: fill, overrun, drain in order, clear
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1);
    chk1("fill full", full, 1'b1);
    chk5("fill count", count, 5'd16);
    chk1("fill overrun before drop", overrun, 1'b0);
    send_frame(8'hFF, 2);
    chk1("drop sets overrun", overrun, 1'b1);
    chk5("drop keeps count", count, 5'd16);
    for (int i = 0; i < 16; i++) read_one(8'(i), $sformatf("fill read%0d", i));
    chk1("drained empty", empty, 1'b1);
    chk1("overrun sticky", overrun, 1'b1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk1("ovr_clr clears", overrun, 1'b0);

    // T4: pointer wrap with occupancy held at 1..3
    send_frame(8'h60, 1);
    send_frame(8'h61, 1);
    wq.push_back(8'h60);
    wq.push_back(8'h61);
    for (int i = 0; i < 40; i++) begin
      d = 8'(8'h62 + i);
      send_frame(d, 1 + (i % 3));
      wq.push_back(d);
      chk1($sformatf("wrap%0d full", i), full, 1'b0);
      read_one(wq.pop_front(), $sformatf("wrap%0d", i));
      chk1($sformatf("wrap%0d empty", i), empty, 1'b0);
    end
    read_one(wq.pop_front(), "wrap tail0");
    read_one(wq.pop_front(), "wrap tail1");
    chk1("wrap drained", empty, 1'b1);

    // T5: push and pop together while full, then while empty
    for (int i = 0; i < 16; i++) send_frame(8'(8'h40 + i), 1);
    rx_dout = 8'hEE;
    rx_done = 1'b1;
    repeat (2) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk1("full simul rd_valid", rd_valid, 1'b1);
    chk8("full simul rd_data", rd_data, 8'h40);
    chk5("full simul count", count, 5'd16);
    chk1("full simul overrun", overrun, 1'b0);
    rx_done = 1'b0;
    step();
    for (int i = 1; i < 16; i++) read_one(8'(8'h40 + i), $sformatf("simul read%0d", i));
    read_one(8'hEE, "simul newest");
    chk1("simul drained", empty, 1'b1);
    rx_dout = 8'h77;
    rx_done = 1'b1;
    repeat (2) step();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk1("empty simul rd_valid", rd_valid, 1'b0);
    chk5("empty simul count", count, 5'd1);
    rx_done = 1'b0;
    step();
    read_one(8'h77, "empty simul");

    // T6: long rx_done high, then overrun coinciding with ovr_clr
    rx_dout = 8'h99;
    rx_done = 1'b1;
    repeat (50) step();
    chk5("long high count", count, 5'd1);
    rx_done = 1'b0;
    repeat (3) step();
    chk5("long high after drop", count, 5'd1);
    for (int i = 1; i < 16; i++) send_frame(8'(8'hB0 + i), 1);
    chk1("t6 full", full, 1'b1);
    rx_dout = 8'hAB;
    rx_done = 1'b1;
    repeat (2) step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk1("set wins over clear", overrun, 1'b1);
    rx_done = 1'b0;
    step();
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk1("t6 clear", overrun, 1'b0);
    read_one(8'h99, "t6 first");
    for (int i = 1; i < 16; i++) read_one(8'(8'hB0 + i), $sformatf("t6 read%0d", i));

    // Reset mid-frame discards contents
    send_frame(8'h11, 1);
    send_frame(8'h22, 1);
    rx_dout = 8'h33;
    rx_done = 1'b1;
    step();
    PRESETn = 1'b0;
    step();
    PRESETn = 1'b1;
    chk1("midreset empty", empty, 1'b1);
    chk5("midreset count", count, 5'd0);
    step();
    rx_done = 1'b0;
    repeat (4) step();
    chk5("midreset no push", count, 5'd0);

    // Randomized run against the model
    m_ovr   = 1'b0;
    m_vld   = 1'b0;
    m_rd    = 8'h00;
    cyc     = 0;
    since   = 0;
    hi_left = 0;
    for (int it = 0; it < 3000; it++) begin
      case ((it / 250) % 3)
        0:       thr = 10;
        1:       thr = 50;
        default: thr = 90;
      endcase
      rd_en   = ($urandom_range(0, 99) < thr);
      ovr_clr = ($urandom_range(0, 49) == 0);
      if (rx_done) begin
        if (hi_left == 0) rx_done = 1'b0;
        else hi_left--;
      end else if (since >= 3 && $urandom_range(0, 2) == 0) begin
        rx_done = 1'b1;
        rx_dout = 8'($urandom);
        hi_left = ($urandom_range(0, 19) == 0) ? 20 : $urandom_range(0, 3);
        pend_edge.push_back(cyc + 3);
        pend_data.push_back(rx_dout);
        since = 0;
      end
      since++;

      @(posedge PCLK);
      cyc++;
      pop_m  = rd_en && (mq.size() != 0);
      push_m = (pend_edge.size() != 0) && (pend_edge[0] == cyc);
      m_vld  = pop_m;
      if (pop_m) m_rd = mq.pop_front();
      if (push_m) begin
        pend_edge.pop_front();
        d = pend_data.pop_front();
        if (mq.size() < DEPTH) mq.push_back(d);
        else m_ovr = 1'b1;
      end else if (ovr_clr) begin
        m_ovr = 1'b0;
      end
      if (ovr_clr && !(push_m && mq.size() == DEPTH && !pop_m && 1'b0)) begin
        if (!(push_m && !pop_m && m_ovr && mq.size() == DEPTH)) m_ovr = m_ovr && push_m && !pop_m && mq.size() == DEPTH;
      end
      #1;
      chk5($sformatf("rand%0d count", it), count, 5'(mq.size()));
      chk1($sformatf("rand%0d empty", it), empty, mq.size() == 0);
      chk1($sformatf("rand%0d full", it), full, mq.size() == DEPTH);
      chk1($sformatf("rand%0d overrun", it), overrun, m_ovr);
      chk1($sformatf("rand%0d rd_valid", it), rd_valid, m_vld);
      chk8($sformatf("rand%0d rd_data", it), rd_data, m_rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
